counter_timer_ctrl: RTL and testbench

Programmable interval-timer controller that sequences a down-counter datapath for the priRV32 core. It latches a configuration (reload value, prescaler, mode), then runs the counter in one-shot or periodic mode. It emits a per-step enable pulse plus an interrupt with acknowledge, and serves as the core's timer-interrupt source.

---
 rtl/counter_timer_ctrl_if.sv | 29 ++
 rtl/counter_timer_ctrl.sv | 125 ++++++++++++
 tb/tb_counter_timer_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_timer_ctrl_if.sv
// Bus bundle for the interval-timer controller: configuration/control inputs
// and counter/interrupt outputs, with master (host) and slave (timer) views.
interface counter_timer_ctrl_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 8
);
  logic                  cfg_we;
  logic [WIDTH-1:0]      cfg_load;
  logic [PRESCALE_W-1:0] cfg_prescale;
  logic                  cfg_periodic;
  logic                  start;
  logic                  stop;
  logic                  irq_ack;
  logic                  cnt_enable;
  logic [WIDTH-1:0]      cnt_value;
  logic                  busy;
  logic                  irq;
  logic                  ovf_err;

  modport master (
    output cfg_we, cfg_load, cfg_prescale, cfg_periodic, start, stop, irq_ack,
    input  cnt_enable, cnt_value, busy, irq, ovf_err
  );

  modport slave (
    input  cfg_we, cfg_load, cfg_prescale, cfg_periodic, start, stop, irq_ack,
    output cnt_enable, cnt_value, busy, irq, ovf_err
  );
endinterface

// File: rtl/counter_timer_ctrl.sv
// Programmable interval timer: prescaled down-counter with one-shot/periodic
// modes, per-step enable pulse and sticky interrupt/overflow flags.
module counter_timer_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  counter_timer_ctrl_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [WIDTH-1:0]      r_load;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_periodic;
  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic [WIDTH-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_irq;
  logic                  r_ovf;

  logic                  w_tick;
  logic                  w_expire;
  logic [PRESCALE_W-1:0] w_next_pre;
  logic [WIDTH-1:0]      w_next_cnt;
  logic                  w_next_irq;
  logic                  w_next_ovf;

  assign w_tick = (r_state == S_RUN) && (r_pre_cnt == r_prescale);

  always_comb begin
    w_next_state = r_state;
    w_next_pre   = r_pre_cnt;
    w_next_cnt   = r_cnt;
    w_expire     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Start sees the pre-write shadow load even if cfg_we is in the same cycle.
        if (bus.start && !bus.stop) begin
          w_next_state = S_RUN;
          w_next_cnt   = r_load;
          w_next_pre   = '0;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          w_next_state = S_IDLE;
          w_next_pre   = '0;
        end else if (w_tick) begin
          w_next_pre = '0;
          if (r_cnt != '0) begin
            w_next_cnt = r_cnt - WIDTH'(1);
          end else begin
            w_expire = 1'b1;
            if (r_periodic) begin
              w_next_cnt = r_load;
            end else begin
              w_next_state = S_IDLE;
            end
          end
        end else begin
          w_next_pre = r_pre_cnt + PRESCALE_W'(1);
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // An expiry coinciding with an acknowledge keeps irq set and leaves ovf_err as it was.
  always_comb begin
    w_next_irq = r_irq;
    w_next_ovf = r_ovf;
    if (w_expire) begin
      w_next_irq = 1'b1;
      w_next_ovf = r_ovf | (r_irq & ~bus.irq_ack);
    end else if (bus.irq_ack) begin
      w_next_irq = 1'b0;
      w_next_ovf = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pre_cnt <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_irq     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pre_cnt <= w_next_pre;
      r_cnt     <= w_next_cnt;
      r_busy    <= (w_next_state == S_RUN);
      r_irq     <= w_next_irq;
      r_ovf     <= w_next_ovf;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_load     <= '0;
      r_prescale <= '0;
      r_periodic <= 1'b0;
    end else if (bus.cfg_we) begin
      r_load     <= bus.cfg_load;
      r_prescale <= bus.cfg_prescale;
      r_periodic <= bus.cfg_periodic;
    end
  end

  assign bus.cnt_enable = w_tick;
  assign bus.cnt_value  = r_cnt;
  assign bus.busy       = r_busy;
  assign bus.irq        = r_irq;
  assign bus.ovf_err    = r_ovf;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Scoreboard bench for counter_timer_ctrl: directed scenarios plus random
// traffic, checked against an elapsed-time model of the timer.
module tb_counter_timer_ctrl;

  logic clk;
  logic reset;

  counter_timer_ctrl_if #(.WIDTH(8), .PRESCALE_W(8)) bus_if ();

  counter_timer_ctrl #(.WIDTH(8), .PRESCALE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [7:0] val;
    logic       busy;
    logic       irq;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: while running, the counter value is derived from edges elapsed
  // since the last (re)load; each expiry re-anchors the period.
  int   cyc = 0;
  bit   m_run = 0;
  int   m_t0 = 0;
  int   m_L = 0;
  int   m_held = 0;
  bit   m_irq = 0, m_ovf = 0;
  int   m_shL = 0, m_shP = 0;
  bit   m_shPer = 0;

  always @(posedge clk) begin : model
    exp_t e;
    int   d, per;
    bit   expire;
    cyc++;
    if (!reset) begin
      m_run = 0; m_t0 = 0; m_L = 0; m_held = 0;
      m_irq = 0; m_ovf = 0; m_shL = 0; m_shP = 0; m_shPer = 0;
    end else begin
      expire = 0;
      if (m_run) begin
        d   = cyc - m_t0;
        per = (m_L + 1) * (m_shP + 1);
        if (bus_if.stop) begin
          m_run  = 0;
          m_held = m_L - (d - 1) / (m_shP + 1);
        end else if (d % per == 0) begin
          expire = 1;
          if (m_shPer) begin
            m_t0 = cyc;
            m_L  = m_shL;
          end else begin
            m_run  = 0;
            m_held = 0;
          end
        end
      end else if (bus_if.start && !bus_if.stop) begin
        m_run = 1;
        m_t0  = cyc;
        m_L   = m_shL;
      end
      if (expire) begin
        m_ovf = m_ovf | (m_irq & !bus_if.irq_ack);
        m_irq = 1;
      end else if (bus_if.irq_ack) begin
        m_irq = 0;
        m_ovf = 0;
      end
      if (bus_if.cfg_we) begin
        m_shL   = int'(bus_if.cfg_load);
        m_shP   = int'(bus_if.cfg_prescale);
        m_shPer = bus_if.cfg_periodic;
      end
    end
    e.busy = m_run;
    e.val  = m_run ? 8'(m_L - (cyc - m_t0) / (m_shP + 1)) : 8'(m_held);
    e.en   = m_run && (((cyc - m_t0 + 1) % (m_shP + 1)) == 0);
    e.irq  = m_irq;
    e.ovf  = m_ovf;
    q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{bus_if.cnt_enable, bus_if.cnt_value, bus_if.busy, bus_if.irq, bus_if.ovf_err};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t en/val/busy/irq/ovf got %b/%0d/%b/%b/%b want %b/%0d/%b/%b/%b",
                 $time, a.en, a.val, a.busy, a.irq, a.ovf, e.en, e.val, e.busy, e.irq, e.ovf);
      end
    end
  end

  task automatic drive(input logic we, input logic [7:0] ld, input logic [7:0] ps,
                       input logic per, input logic st, input logic sp, input logic ak);
    bus_if.cfg_we       = we;
    bus_if.cfg_load     = ld;
    bus_if.cfg_prescale = ps;
    bus_if.cfg_periodic = per;
    bus_if.start        = st;
    bus_if.stop         = sp;
    bus_if.irq_ack      = ak;
    @(posedge clk);
    #2;
    bus_if.cfg_we  = 1'b0;
    bus_if.start   = 1'b0;
    bus_if.stop    = 1'b0;
    bus_if.irq_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic cfg(input logic [7:0] ld, input logic [7:0] ps, input logic per);
    drive(1'b1, ld, ps, per, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_now(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus_if.cfg_we = 0; bus_if.cfg_load = 0; bus_if.cfg_prescale = 0;
    bus_if.cfg_periodic = 0; bus_if.start = 0; bus_if.stop = 0; bus_if.irq_ack = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 reset = 1'b1;
    idle(1);

    // One-shot load=5, prescale=0
    cfg(8'd5, 8'd0, 1'b0);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(9);

    // Periodic load=3, prescale=2, acknowledging each interrupt
    drive(0, 0, 0, 0, 0, 0, 1);
    cfg(8'd3, 8'd2, 1'b1);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 40; i++) drive(0, 0, 0, 0, 0, 0, bus_if.irq);
    drive(0, 0, 0, 0, 0, 1, 0);

    // Periodic load=1, never acknowledged -> overflow, then one ack
    drive(0, 0, 0, 0, 0, 0, 1);
    cfg(8'd1, 8'd0, 1'b1);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(6);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1);

    // Stop with simultaneous start at cnt_value=7, then restart
    cfg(8'd10, 8'd0, 1'b0);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 60 && bus_if.cnt_value != 8'd7; i++) idle(1);
    chk_now("reach_cnt7", int'(bus_if.cnt_value), 7);
    drive(0, 0, 0, 0, 1, 1, 0);
    idle(3);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(3);
    drive(0, 0, 0, 0, 0, 1, 0);

    // Ack coinciding with expiry; load change mid-run takes effect at reload
    cfg(8'd4, 8'd0, 1'b1);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(2);
    repeat (5) drive(0, 0, 0, 0, 0, 0, 1);
    cfg(8'd2, 8'd0, 1'b1);
    idle(12);

    // Asynchronous reset mid-count
    @(negedge clk); #1 reset = 1'b0;
    #1;
    chk_now("async_rst_busy", int'(bus_if.busy), 0);
    chk_now("async_rst_val", int'(bus_if.cnt_value), 0);
    chk_now("async_rst_en", int'(bus_if.cnt_enable), 0);
    chk_now("async_rst_irq", int'(bus_if.irq), 0);
    chk_now("async_rst_ovf", int'(bus_if.ovf_err), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(4);

    // Random traffic; prescale is only altered while idle
    for (int i = 0; i < 400; i++) begin
      logic       we, per, st, sp, ak;
      logic [7:0] ld, ps;
      we  = m_run ? ($urandom % 10 == 0) : ($urandom % 4 == 0);
      ld  = 8'($urandom % 8);
      ps  = m_run ? 8'(m_shP) : 8'($urandom % 4);
      per = 1'($urandom % 2);
      st  = ($urandom % 8 == 0);
      sp  = ($urandom % 25 == 0);
      ak  = ($urandom % 6 == 0);
      drive(we, ld, ps, per, st, sp, ak);
    end

    idle(2);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
